// File: rtl/rr_counter_arbiter.sv
// Round-robin arbiter that serialises increment/decrement requests from NUM_REQ
// clients onto one shared wrap-around counter and returns the post-update value.
module rr_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_up,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        clr,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  resp_id,
    output logic [WIDTH-1:0]            resp_count,
    output logic [WIDTH-1:0]            count,
    output logic                        busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   last_grant_reg, last_grant_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic              up_reg, up_next;
    logic [WIDTH-1:0]  count_reg, count_next;
    logic [ID_W-1:0]   resp_id_reg, resp_id_next;
    logic [WIDTH-1:0]  resp_count_reg, resp_count_next;

    logic              any_valid;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand_id;
    logic              exec_take;

    assign any_valid = |req_valid;

    // Scan from the farthest candidate back to the nearest so the requester
    // closest after last_grant overwrites the others and wins.
    always_comb begin
        pick_id = '0;
        cand_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_id = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (req_valid[cand_id]) begin
                pick_id = cand_id;
            end
        end
    end

    // A granted op is consumed only if its requester still holds valid in EXEC.
    assign exec_take = (state_reg == EXEC) && req_valid[grant_id_reg];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = exec_take && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        up_next         = up_reg;
        count_next      = count_reg;
        resp_id_next    = resp_id_reg;
        resp_count_next = resp_count_reg;

        case (state_reg)
            IDLE: begin
                if (clr) begin
                    count_next = '0;
                end else if (any_valid) begin
                    grant_id_next = pick_id;
                    up_next       = req_up[pick_id];
                    state_next    = EXEC;
                end
            end

            EXEC: begin
                if (clr) begin
                    count_next = '0;
                end
                if (!req_valid[grant_id_reg]) begin
                    state_next = IDLE;
                end else begin
                    if (!clr) begin
                        count_next = up_reg ? (count_reg + WIDTH'(1))
                                            : (count_reg - WIDTH'(1));
                    end
                    resp_count_next = count_next;
                    resp_id_next    = grant_id_reg;
                    state_next      = RESP;
                end
            end

            RESP: begin
                if (clr) begin
                    count_next = '0;
                end
                if (resp_ready) begin
                    last_grant_next = grant_id_reg;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            up_reg         <= 1'b0;
            count_reg      <= '0;
            resp_id_reg    <= '0;
            resp_count_reg <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            up_reg         <= up_next;
            count_reg      <= count_next;
            resp_id_reg    <= resp_id_next;
            resp_count_reg <= resp_count_next;
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_id    = resp_id_reg;
    assign resp_count = resp_count_reg;
    assign count      = count_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_rr_counter_arbiter.sv
// Directed plus randomized checks of rr_counter_arbiter against a transaction-level
// model: round-robin pick by modular search, counter kept as an int modulo 256.
module tb_rr_counter_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_up;
    logic [3:0]  req_ready;
    logic        clr;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_count;
    logic [7:0]  count;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int         ref_count;
    int         ref_last;
    logic [3:0] pend;
    logic [3:0] pend_up;

    rr_counter_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_up     (req_up),
        .req_ready  (req_ready),
        .clr        (clr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_count (resp_count),
        .count      (count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant(input logic [3:0] p, input int last);
        logic [1:0] ix;
        for (int k = 1; k <= N; k++) begin
            ix = 2'((last + k) % N);
            if (p[ix]) return int'(ix);
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0; req_up = '0; clr = 1'b0; resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_count = 0;
        ref_last  = N - 1;
        pend = '0; pend_up = '0;
    endtask

    // mode 0: granted client stops; 1: granted client re-requests; 2: all clients stop
    task automatic run_txn(input int stall, input int mode, input bit clr_exec);
        int g;
        g = exp_grant(pend, ref_last);
        req_valid = pend;
        req_up    = pend_up;
        clr       = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("grant_ready", 32'(req_ready), 32'(1 << g));
        chk("exec_busy", 32'(busy), 32'd1);
        if (clr_exec) begin
            clr = 1'b1;
            ref_count = 0;
        end else begin
            ref_count = (ref_count + (pend_up[2'(g)] ? 1 : 255)) % 256;
        end
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        if (mode == 0) pend[2'(g)] = 1'b0;
        if (mode == 2) pend = '0;
        req_valid = pend;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(g));
        chk("resp_count", 32'(resp_count), 32'(ref_count));
        chk("count", 32'(count), 32'(ref_count));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_id", 32'(resp_id), 32'(g));
            chk("stall_count", 32'(resp_count), 32'(ref_count));
            chk("stall_no_ready", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        ref_last = g;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd0);
        $display("[TB] txn grant=%0d resp_count=%0d stall=%0d clr=%0d", g, ref_count, stall, clr_exec);
    endtask

    initial begin
        logic [3:0] nb;
        rst_n = 1'b0;
        req_valid = '0; req_up = '0; clr = 1'b0; resp_ready = 1'b0;
        ref_count = 0; ref_last = N - 1; pend = '0; pend_up = '0;
        repeat (2) @(negedge clk);
        chk("init_resp_id", 32'(resp_id), 32'd0);
        chk("init_resp_count", 32'(resp_count), 32'd0);
        chk("init_count", 32'(count), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // single up op from requester 0
        pend = 4'b0001; pend_up = 4'b0001;
        run_txn(0, 0, 1'b0);

        // all four continuously requesting up: order follows round robin
        do_reset();
        pend = 4'b1111; pend_up = 4'b1111;
        for (int i = 0; i < 4; i++) run_txn(0, 1, 1'b0);
        run_txn(0, 2, 1'b0);

        // wrap-around both ways
        pend = 4'b0100; pend_up = 4'b0000;
        run_txn(0, 0, 1'b1);
        pend = 4'b0100; pend_up = 4'b0000;
        run_txn(0, 0, 1'b0);
        pend = 4'b0100; pend_up = 4'b0100;
        run_txn(0, 0, 1'b0);
        pend = 4'b0100; pend_up = 4'b0000;
        run_txn(5, 0, 1'b0);

        // build count up to 7 then clear during EXEC
        pend = 4'b1000; pend_up = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            pend = 4'b1000;
            run_txn(0, 0, 1'b0);
        end
        pend = 4'b0001; pend_up = 4'b0001;
        run_txn(1, 0, 1'b1);

        // clr in IDLE defers the grant by one cycle
        pend = 4'b0001; pend_up = 4'b0001;
        run_txn(0, 0, 1'b0);
        @(negedge clk);
        req_valid = 4'b0010; req_up = 4'b0010; clr = 1'b1;
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        ref_count = 0;
        chk("idle_clr_count", 32'(count), 32'd0);
        chk("idle_clr_busy", 32'(busy), 32'd0);
        chk("idle_clr_ready", 32'(req_ready), 32'd0);
        pend = 4'b0010; pend_up = 4'b0010;
        run_txn(0, 0, 1'b0);

        // illegal withdrawal in EXEC aborts without update
        pend = 4'b0100; pend_up = 4'b0100;
        req_valid = pend; req_up = pend_up;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(count), 32'(ref_count));
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        pend = 4'b1101; pend_up = 4'b0101;
        run_txn(0, 2, 1'b0);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            nb = 4'($urandom);
            pend_up = (pend_up & pend) | (4'($urandom) & ~pend);
            pend = pend | nb;
            if (pend == 4'b0000) pend = 4'b0001;
            run_txn(int'($urandom_range(0, 3)), (it == 23) ? 2 : int'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
        end

        // asynchronous reset in RESP
        pend = 4'b0010; pend_up = 4'b0010;
        req_valid = pend; req_up = pend_up;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_resp_valid", 32'(resp_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_count = 0; ref_last = N - 1; pend = '0; pend_up = '0;
        pend = 4'b0110; pend_up = 4'b0000;
        run_txn(0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
